filter_ram_ctrl: RTL and testbench

Sequencer and two-way arbiter in front of the 576-word filter RAM (64 filters × 9 taps, 16-bit). Shares the single RAM port between a load requester (host writes filter coefficients one word at a time) and a fetch requester (convolution engine pulls a whole 3×3 filter as a 9-tap burst). Drives the RAM address/write/enable lines and returns fetched taps as a registered valid-qualified stream.

---
 rtl/nn_filter_pkg.sv | 34 +++
 rtl/filter_ram_arb.sv | 42 ++++
 rtl/filter_ram_ctrl.sv | 143 ++++++++++++++
 tb/tb_filter_ram_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_filter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nn_filter_pkg : shared constants and encodings for the filter RAM controller
// Rev 1.0
// ---------------------------------------------------------------------------
package nn_filter_pkg;

  localparam int DEPTH  = 576;
  localparam int TAPS   = 9;
  localparam int FIDX_W = 6;
  localparam int DATA_W = 16;
  // Wide enough to hold DEPTH itself so out-of-range loads are representable.
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TAP_W  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_e;

  typedef enum logic {
    GRANT_LOAD  = 1'b0,
    GRANT_FETCH = 1'b1
  } grant_e;

  // Base word of a filter: f*9 built as (f<<3)+f to avoid a multiplier.
  function automatic logic [ADDR_W-1:0] filter_base(input logic [FIDX_W-1:0] f);
    logic [ADDR_W-1:0] fw;
    fw = {{(ADDR_W-FIDX_W){1'b0}}, f};
    return (fw << 3) + fw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/filter_ram_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// filter_ram_arb : two-way round-robin between host loads and filter fetches
// Rev 1.0
// ---------------------------------------------------------------------------
module filter_ram_arb
  import nn_filter_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic grant_en,
  input  logic load_valid,
  input  logic fetch_req,
  output logic load_ready,
  output logic fetch_grant
);

  grant_e last_grant_q, last_grant_d;

  // Fetch yields only when a load is also waiting and fetch won last time.
  always_comb begin
    fetch_grant  = grant_en && fetch_req &&
                   (!load_valid || (last_grant_q == GRANT_LOAD));
    load_ready   = grant_en && !fetch_grant;
    last_grant_d = last_grant_q;
    if (fetch_grant) begin
      last_grant_d = GRANT_FETCH;
    end else if (load_valid && load_ready) begin
      last_grant_d = GRANT_LOAD;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_LOAD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/filter_ram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// filter_ram_ctrl : shares the filter RAM port between coefficient loads and
// 9-tap filter fetch bursts. Rev 1.0
// ---------------------------------------------------------------------------
module filter_ram_ctrl
  import nn_filter_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  input  logic              fetch_req,
  input  logic [FIDX_W-1:0] fetch_filter,
  output logic              fetch_ack,
  output logic              fetch_busy,
  output logic              tap_valid,
  output logic [DATA_W-1:0] tap_data,
  output logic [TAP_W-1:0]  tap_index,
  output logic              tap_last,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              ram_enable,
  output logic              ram_write
);

  state_e            state_q, state_d;
  logic [TAP_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] tap_data_q, tap_data_d;
  logic [TAP_W-1:0]  tap_index_q, tap_index_d;
  logic              tap_valid_q, tap_valid_d;
  logic              tap_last_q, tap_last_d;
  logic              load_err_q, load_err_d;

  logic grant_en;
  logic fetch_grant;
  logic load_accept;
  logic addr_ok;

  // Gating with reset_n keeps every strobe low while reset is asserted.
  assign grant_en    = (state_q == ST_IDLE) && reset_n;
  assign load_accept = load_valid && load_ready;
  assign addr_ok     = load_addr < ADDR_W'(DEPTH);

  filter_ram_arb u_arb (
    .clock       (clock),
    .reset_n     (reset_n),
    .grant_en    (grant_en),
    .load_valid  (load_valid),
    .fetch_req   (fetch_req),
    .load_ready  (load_ready),
    .fetch_grant (fetch_grant)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    base_d         = base_q;
    wdata_d        = wdata_q;
    tap_data_d     = tap_data_q;
    tap_index_d    = tap_index_q;
    tap_valid_d    = 1'b0;
    tap_last_d     = 1'b0;
    load_err_d     = 1'b0;
    ram_address    = '0;
    ram_write_data = wdata_q;
    ram_enable     = 1'b0;
    ram_write      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fetch_grant) begin
          base_d  = filter_base(fetch_filter);
          count_d = '0;
          state_d = ST_FETCH;
        end else if (load_accept) begin
          ram_address    = load_addr;
          ram_write_data = load_data;
          ram_enable     = 1'b1;
          ram_write      = addr_ok;
          wdata_d        = load_data;
          load_err_d     = !addr_ok;
        end
      end
      ST_FETCH: begin
        ram_address = base_q + ADDR_W'(count_q);
        ram_enable  = 1'b1;
        // Read data settles within the cycle, so capture it with its index.
        tap_valid_d = 1'b1;
        tap_data_d  = ram_read_data;
        tap_index_d = count_q;
        tap_last_d  = (count_q == TAP_W'(TAPS - 1));
        if (count_q == TAP_W'(TAPS - 1)) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      tap_data_q  <= '0;
      tap_index_q <= '0;
      tap_valid_q <= 1'b0;
      tap_last_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      tap_data_q  <= tap_data_d;
      tap_index_q <= tap_index_d;
      tap_valid_q <= tap_valid_d;
      tap_last_q  <= tap_last_d;
      load_err_q  <= load_err_d;
    end
  end

  assign fetch_ack  = fetch_grant;
  assign fetch_busy = (state_q == ST_FETCH) || tap_valid_q;
  assign tap_valid  = tap_valid_q;
  assign tap_data   = tap_data_q;
  assign tap_index  = tap_index_q;
  assign tap_last   = tap_last_q;
  assign load_err   = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_filter_ram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_filter_ram_ctrl : directed self-checking bench with a behavioural RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_filter_ram_ctrl;
  import nn_filter_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;
  logic              fetch_req;
  logic [FIDX_W-1:0] fetch_filter;
  logic              fetch_ack;
  logic              fetch_busy;
  logic              tap_valid;
  logic [DATA_W-1:0] tap_data;
  logic [TAP_W-1:0]  tap_index;
  logic              tap_last;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_write_data;
  logic [DATA_W-1:0] ram_read_data;
  logic              ram_enable;
  logic              ram_write;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              do_preload;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  filter_ram_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_err       (load_err),
    .fetch_req      (fetch_req),
    .fetch_filter   (fetch_filter),
    .fetch_ack      (fetch_ack),
    .fetch_busy     (fetch_busy),
    .tap_valid      (tap_valid),
    .tap_data       (tap_data),
    .tap_index      (tap_index),
    .tap_last       (tap_last),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data),
    .ram_enable     (ram_enable),
    .ram_write      (ram_write)
  );

  assign ram_read_data = mem[ram_address];

  always @(posedge clock) begin
    if (do_preload) begin
      for (int k = 0; k < (1 << ADDR_W); k++) mem[k] <= DATA_W'(k);
    end else if (ram_enable && ram_write) begin
      mem[ram_address] <= ram_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    int ack_cyc;
    reset_n = 1'b0; do_preload = 1'b1;
    load_valid = 1'b0; load_addr = '0; load_data = '0;
    fetch_req = 1'b0; fetch_filter = '0;

    // Reset held three cycles
    repeat (3) tick();
    do_preload = 1'b0;
    chk("rst_load_ready", load_ready, 0);
    chk("rst_fetch_ack", fetch_ack, 0);
    chk("rst_fetch_busy", fetch_busy, 0);
    chk("rst_tap_valid", tap_valid, 0);
    chk("rst_tap_last", tap_last, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_ram_enable", ram_enable, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_address", ram_address, 0);
    reset_n = 1'b1;
    #1;
    chk("idle_load_ready", load_ready, 1);

    // Fetch filter 63 from preloaded RAM (mem[k] = k)
    fetch_req = 1'b1; fetch_filter = 6'd63;
    #1;
    chk("f63_ack", fetch_ack, 1);
    chk("f63_load_ready", load_ready, 0);
    tick();
    fetch_req = 1'b0;
    n = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) tick();
      if (c <= 9) begin
        chk("f63_addr", ram_address, 567 + c - 1);
        chk("f63_rd_only", {ram_enable, ram_write}, 2'b10);
      end
      if (tap_valid) n++;
      if (c >= 2 && c <= 10) begin
        chk("f63_tap_valid", tap_valid, 1);
        chk("f63_tap_data", tap_data, 567 + c - 2);
        chk("f63_tap_index", tap_index, c - 2);
        chk("f63_tap_last", tap_last, (c == 10) ? 1 : 0);
      end
    end
    chk("f63_valid_count", n, 9);
    chk("f63_end_valid", tap_valid, 0);
    chk("f63_end_busy", fetch_busy, 0);

    // Loads: in-range then out-of-range
    load_valid = 1'b1; load_addr = 10'd575; load_data = 16'hA5A5;
    #1;
    chk("ld575_ready", load_ready, 1);
    chk("ld575_addr", ram_address, 575);
    chk("ld575_we", {ram_enable, ram_write}, 2'b11);
    tick();
    load_addr = 10'd576; load_data = 16'h1234;
    #1;
    chk("ld576_we", {ram_enable, ram_write}, 2'b10);
    chk("ld576_err_early", load_err, 0);
    tick();
    load_valid = 1'b0;
    #1;
    chk("ld576_err", load_err, 1);
    chk("ld576_wdata_hold", ram_write_data, 16'h1234);
    chk("ram575", mem[575], 16'hA5A5);
    chk("ram576", mem[576], 16'd576);
    tick();
    chk("ld576_err_pulse", load_err, 0);

    // Back-to-back fetches: filter 0 then 1
    fetch_req = 1'b1; fetch_filter = 6'd0;
    #1;
    chk("b2b_ack0", fetch_ack, 1);
    n = 0; ack_cyc = 0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 1) begin
        fetch_filter = 6'd1;
        #1;
      end
      if (fetch_ack && ack_cyc == 0) ack_cyc = c;
      if (c == 11) fetch_req = 1'b0;
      if (tap_valid) begin
        chk("b2b_tap_data", tap_data, n);
        n++;
      end
    end
    chk("b2b_ack_cycle", ack_cyc, 10);
    chk("b2b_tap_count", n, 18);

    // Abort a burst with asynchronous reset
    fetch_req = 1'b1; fetch_filter = 6'd2;
    tick();
    fetch_req = 1'b0;
    repeat (4) tick();
    chk("abort_busy_pre", fetch_busy, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_tap_valid", tap_valid, 0);
    chk("abort_ram_enable", ram_enable, 0);
    chk("abort_busy", fetch_busy, 0);

    // Both requesters active out of reset: fetch, one load, fetch
    load_valid = 1'b1; load_addr = 10'd100; load_data = 16'hBEEF;
    fetch_req = 1'b1; fetch_filter = 6'd4;
    tick();
    chk("both_rst_ready", load_ready, 0);
    chk("both_rst_ack", fetch_ack, 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("both_ack1", fetch_ack, 1);
    chk("both_ready1", load_ready, 0);
    n = 0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c <= 9 && load_ready) n++;
      if (c == 10) begin
        chk("both_load_ready", load_ready, 1);
        chk("both_load_ack", fetch_ack, 0);
        chk("both_load_addr", ram_address, 100);
        chk("both_load_we", ram_write, 1);
      end
      if (c == 11) begin
        chk("both_ack2", fetch_ack, 1);
        chk("both_ready2", load_ready, 0);
        chk("ram100", mem[100], 16'hBEEF);
        load_valid = 1'b0;
        fetch_req  = 1'b0;
      end
    end
    chk("both_ready_in_burst", n, 0);
    repeat (11) tick();
    chk("final_busy", fetch_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
